// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic requests into MIPS words written to imem; ENC_LI_EXPAND_EN adds LI -> LUI+ORI
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [31:0]       req_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic        run, acc, li, last, li_go, lo, emit;
  logic [4:0]  lo_rt;
  logic [15:0] lo_imm;
  logic [31:0] enc, nxt;
  assign full      = count[ADDR_W];
  assign last      = count == (ADDR_W + 1)'(DEPTH - 1);
  assign req_ready = run & ~reset & ~full & ~lo;
  assign acc       = req_valid & req_ready;
  assign li        = req_kind == 4'd15;
`ifdef ENC_LI_EXPAND_EN
  assign li_go = acc & li & ~last;
  always_ff @(posedge clk) begin
    if (reset) begin
      lo     <= 1'b0;
      lo_rt  <= '0;
      lo_imm <= '0;
    end else begin
      lo <= li_go;
      if (li_go) begin
        lo_rt  <= req_rt;
        lo_imm <= req_imm[15:0];
      end
    end
  end
`else
  assign li_go  = 1'b0;
  assign lo     = 1'b0;
  assign lo_rt  = '0;
  assign lo_imm = '0;
`endif
  always_comb begin
    enc = '0;
    case (req_kind)
      4'd0:  enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100001};
      4'd1:  enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100011};
      4'd2:  enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100100};
      4'd3:  enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100101};
      4'd4:  enc = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b101011};
      4'd5:  enc = {6'b100011, req_rs, req_rt, req_imm[15:0]};
      4'd6:  enc = {6'b101011, req_rs, req_rt, req_imm[15:0]};
      4'd7:  enc = {6'b000100, req_rs, req_rt, req_imm[15:0]};
      4'd8:  enc = {6'b001001, req_rs, req_rt, req_imm[15:0]};
      4'd9:  enc = {6'b000010, req_imm[25:0]};
      4'd10: enc = {6'b001111, 5'd0, req_rt, req_imm[15:0]};
      4'd11: enc = {6'b001101, req_rs, req_rt, req_imm[15:0]};
      4'd12: enc = {6'b000001, req_rs, 5'd0, req_imm[15:0]};
      4'd13: enc = {6'b000011, req_imm[25:0]};
      4'd14: enc = {6'b000000, req_rs, 15'd0, 6'b001000};
      default: enc = {6'b001111, 5'd0, req_rt, req_imm[31:16]};
    endcase
  end
  assign nxt  = lo ? {6'b001101, lo_rt, lo_rt, lo_imm} : enc;
  assign emit = lo | (acc & (~li | li_go));
  always_ff @(posedge clk) begin
    if (reset) begin
      run     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      run   <= 1'b1;
      wr_en <= emit;
      err   <= err | (acc & li & ~li_go);
      if (emit) begin
        wr_addr <= count[ADDR_W-1:0];
        wr_data <= nxt;
        count   <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against ADDR_W=6 and ADDR_W=2 encoders
module tb_instr_encoder;
  logic        clk = 0, reset = 1, v6 = 0, v2 = 0;
  logic [3:0]  kind = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic [31:0] imm = 0;
  logic        rdy6, we6, full6, err6, rdy2, we2, full2, err2;
  logic [5:0]  addr6;
  logic [1:0]  addr2;
  logic [31:0] data6, data2;
  logic [6:0]  cnt6;
  logic [2:0]  cnt2;
  int          cmp = 0, bad = 0;
  instr_encoder #(.ADDR_W(6)) u6 (.clk(clk), .reset(reset), .req_valid(v6), .req_ready(rdy6),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_imm(imm), .wr_en(we6),
    .wr_addr(addr6), .wr_data(data6), .count(cnt6), .full(full6), .err(err6));
  instr_encoder #(.ADDR_W(2)) u2 (.clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_imm(imm), .wr_en(we2),
    .wr_addr(addr2), .wr_data(data2), .count(cnt2), .full(full2), .err(err2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [31:0] i);
    kind = k; rs = s; rt = t; rd = d; imm = i;
    v6 = ~sel; v2 = sel;
    step();
    v6 = 0; v2 = 0;
  endtask
  initial begin
    step(); step();
    chk("rst_ready", rdy6, 0);
    chk("rst_wr_en", we6, 0);
    chk("rst_data", data6, 0);
    chk("rst_count", cnt6, 0);
    chk("rst_err_full", {err6, full6}, 0);
    reset = 0;
    step();
    chk("ready_after_rst", rdy6, 1);
    send(0, 4'd0, 5'd1, 5'd2, 5'd3, 0);
    chk("addu_en", we6, 1);
    chk("addu_addr", addr6, 0);
    chk("addu_data", data6, 32'h00221821);
    send(0, 4'd5, 5'd29, 5'd8, 5'd0, 32'h4);
    chk("lw_data", data6, 32'h8FA80004);
    chk("lw_addr", addr6, 1);
    send(0, 4'd12, 5'd4, 5'd7, 5'd0, 32'hFFFE);
    chk("bltz_b2b", {31'd0, we6}, 1);
    chk("bltz_data", data6, 32'h0480FFFE);
    chk("bltz_addr", addr6, 2);
    send(0, 4'd13, 5'd0, 5'd0, 5'd0, 32'h10);
    chk("jal_data", data6, 32'h0C000010);
    send(0, 4'd14, 5'd31, 5'd0, 5'd0, 0);
    chk("jr_data", data6, 32'h03E00008);
    chk("count5", cnt6, 5);
    step();
    chk("idle_no_write", we6, 0);
    send(0, 4'd10, 5'd5, 5'd9, 5'd0, 32'hABCD);
    chk("lui_rs0", data6, 32'h3C09ABCD);
    chk("lui_addr", addr6, 5);
    send(0, 4'd15, 5'd0, 5'd9, 5'd0, 32'h12345678);
`ifdef ENC_LI_EXPAND_EN
    chk("li_hi", data6, 32'h3C091234);
    chk("li_hi_addr", addr6, 6);
    chk("li_ready_low", rdy6, 0);
    step();
    chk("li_lo", data6, 32'h35295678);
    chk("li_lo_addr", addr6, 7);
    chk("li_ready_back", rdy6, 1);
    chk("li_err", err6, 0);
    send(0, 4'd15, 5'd0, 5'd9, 5'd0, 32'h12345678);
    reset = 1;
    step();
    chk("rst_lo_no_ori", we6, 0);
`else
    chk("li_ill_no_write", we6, 0);
    chk("li_ill_err", err6, 1);
    chk("li_ill_count", cnt6, 6);
    send(0, 4'd0, 5'd1, 5'd2, 5'd3, 0);
    chk("err_sticky", {err6, addr6}, {1'b1, 6'd6});
    reset = 1;
    step();
    chk("rst_mid_wr_en", we6, 0);
`endif
    chk("rst_mid_count", cnt6, 0);
    chk("rst_mid_err", err6, 0);
    chk("rst_mid_ready", rdy6, 0);
    reset = 0;
    step();
    for (int i = 0; i < 3; i++) send(1, 4'd0, 5'd1, 5'd2, 5'd3, 0);
    chk("w2_count3", cnt2, 3);
    send(1, 4'd15, 5'd0, 5'd9, 5'd0, 32'h12345678);
    chk("w2_li_nowrite", we2, 0);
    chk("w2_li_err", err2, 1);
    chk("w2_li_count", cnt2, 3);
    send(1, 4'd0, 5'd1, 5'd2, 5'd3, 0);
    chk("w2_last_addr", addr2, 3);
    chk("w2_full", {full2, rdy2}, 2'b10);
    chk("w2_count4", cnt2, 4);
    send(1, 4'd0, 5'd1, 5'd2, 5'd3, 0);
    chk("w2_full_no_write", {we2, cnt2}, 4'b0100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
